// File: rtl/reg_file_flags_pkg.sv
// Shared definitions for the architectural register file and status flags.
// Default datapath geometry is 8 registers of 8 bits each.
package reg_file_flags_pkg;

  localparam int kRF_W = 8;
  localparam int kRF_D = 3;

  // Status flags captured from the ALU on writeback.
  typedef struct packed {
    logic sc;
    logic zero;
  } flags_t;

  typedef logic [kRF_D-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_flags_flag_reg.sv
// Two-bit carry/zero flag register with enable and synchronous reset.
// Optional macro RF_BYPASS_EN: when defined, an enabled flag update is
// forwarded combinationally to the outputs in the same cycle.
module flag_reg
  import reg_file_flags_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   wr_en,
  input  flags_t flags_in,
  output flags_t flags_out
);

  flags_t flags_q;

  // Capture the ALU flags on an enabled update; reset always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (wr_en) begin
      flags_q <= flags_in;
    end
  end

`ifdef RF_BYPASS_EN
  // Forward a same-cycle flag update so the ALU sees the fresh carry.
  always_comb begin
    flags_out = flags_q;
    if (wr_en && !reset) begin
      flags_out = flags_in;
    end
  end
`else
  assign flags_out = flags_q;
`endif

endmodule

// File: rtl/reg_file_flags.sv
// Architectural register file (2**D x W) with two combinational read ports
// and the carry/zero status flag register feeding the ALU.
// Optional macro RF_BYPASS_EN: write-through forwarding from the write port
// to both read ports and from the flag inputs to the flag outputs.
module reg_file_flags
  import reg_file_flags_pkg::*;
#(
  parameter int W = kRF_W,
  parameter int D = kRF_D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [D-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [D-1:0] rd_addr_a,
  input  logic [D-1:0] rd_addr_b,
  output logic [W-1:0] dat_a_out,
  output logic [W-1:0] dat_b_out,
  input  logic         flag_wr_en,
  input  logic         sc_in,
  input  logic         zero_in,
  output logic         sc_o,
  output logic         zero_o
);

  localparam int NREGS = 2 ** D;

  logic [W-1:0] regs [NREGS];

  flags_t flags_in;
  flags_t flags_out;

  // Register array: clear everything on reset, otherwise one write per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port A: zero-latency mux, optionally forwarding the pending write.
  always_comb begin
    dat_a_out = regs[rd_addr_a];
`ifdef RF_BYPASS_EN
    if (wr_en && !reset && (rd_addr_a == wr_addr)) begin
      dat_a_out = wr_data;
    end
`endif
  end

  // Read port B: identical to port A, addressed independently.
  always_comb begin
    dat_b_out = regs[rd_addr_b];
`ifdef RF_BYPASS_EN
    if (wr_en && !reset && (rd_addr_b == wr_addr)) begin
      dat_b_out = wr_data;
    end
`endif
  end

  assign flags_in.sc   = sc_in;
  assign flags_in.zero = zero_in;

  flag_reg u_flag_reg (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (flag_wr_en),
    .flags_in  (flags_in),
    .flags_out (flags_out)
  );

  assign sc_o   = flags_out.sc;
  assign zero_o = flags_out.zero;

endmodule

// File: doc/reg_file_flags.md
Name: reg_file_flags

Overview:
- Architectural register file and status-flag register for the 8-bit datapath.
- Sits directly upstream of the ALU: its two read ports drive inA/inB.
- Captures the ALU's rslt, sc_o and zero on writeback.
- Feeds the stored carry flag back to the ALU as sc_i for add-with-carry.

Parameters:
- W, 8, data width in bits (must match ALU datapath).
- D, 3, register address width; 2**D registers (default 8).

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  register write enable
- wr_addr  input  D  destination register address
- wr_data  input  W  write data (ALU rslt or load data, muxed outside)
- rd_addr_a  input  D  read port A address
- rd_addr_b  input  D  read port B address
- dat_a_out  output  W  port A data, to ALU inA
- dat_b_out  output  W  port B data, to ALU inB
- flag_wr_en  input  1  update carry/zero flags this cycle
- sc_in  input  1  carry/shift-carry from ALU sc_o
- zero_in  input  1  zero indication from ALU
- sc_o  output  1  stored carry flag, to ALU sc_i
- zero_o  output  1  stored zero flag, to branch logic

Behaviour:
- Reset:
  - Synchronous: sampled on rising clk edge while reset=1.
  - All 2**D registers clear to 0; sc_o=0; zero_o=0.
  - Reset has priority over wr_en and flag_wr_en in the same cycle.
  - Reset asserted mid-sequence discards any pending write that cycle.
- Register writes:
  - On rising edge with wr_en=1 and reset=0, reg[wr_addr] <= wr_data.
  - All registers, including reg 0, are writable.
  - No write when wr_en=0.
- Reads:
  - Combinational, zero latency.
  - dat_a_out = reg[rd_addr_a]; dat_b_out = reg[rd_addr_b].
  - Both ports may address the same register and return identical data.
- Same-cycle read/write of one address:
  - Without the optional feature, the read returns the old value; the new value is visible the cycle after the edge.
- Flag register:
  - On rising edge with flag_wr_en=1 and reset=0: sc_o <= sc_in; zero_o <= zero_in.
  - Otherwise flags hold their value.
  - Flag and register writes are independent; both may occur in one cycle.
- Widths:
  - wr_data is exactly W bits; no sign extension or truncation inside the block.
  - Addresses are exactly D bits, so wrap-around never occurs.
- Out-of-range X/Z on an address: no requirement; the bench drives known values only.
- No handshake: the block is always ready, one write per cycle maximum.

Optional Feature:
- Macro: RF_BYPASS_EN.
- When defined: write-through forwarding.
  - If wr_en=1, reset=0 and rd_addr_x==wr_addr, dat_x_out = wr_data in that same cycle (both ports independently).
  - The flag outputs forward too: if flag_wr_en=1, sc_o/zero_o present sc_in/zero_in combinationally.
- When not defined: the old value is returned until the clock edge (see Behaviour); the flag outputs are pure register outputs.

Decomposition:
- Shared package definitions:
  - Constants kRF_W=8 and kRF_D=3.
  - Typedef flags_t, a packed struct {logic sc; logic zero;}.
  - Register-index typedef reg_addr_t (logic[kRF_D-1:0]).
- One sub-module, flag_reg: the two-bit flag register with enable, sync reset, and the optional bypass.
- The register array and read muxes stay in reg_file_flags.

Test Plan:
- Reset and clear: assert reset 1 cycle after writing reg3=8'hA5 and setting flags=1,1 -> all reads 8'h00, sc_o=0, zero_o=0.
- Write/read: write reg2=8'h3C, reg5=8'hC3; read A=2, B=5 next cycle -> dat_a_out=8'h3C, dat_b_out=8'hC3; both ports on 5 -> 8'hC3, 8'hC3.
- Same-cycle RAW: reg4=8'h11; write reg4=8'h22 while reading 4 -> without RF_BYPASS_EN 8'h11 then 8'h22 next cycle; with it 8'h22 immediately.
- Flags: flag_wr_en=1, sc_in=1, zero_in=0 -> next cycle sc_o=1, zero_o=0; flag_wr_en=0, sc_in=0 -> sc_o stays 1.
- Reset priority: wr_en=1 to reg7=8'hFF and flag_wr_en=1 with reset=1 same cycle -> reg7=8'h00, flags 0.
- Sweep: write reg i = 8'h10+i for i=0..7, read all pairs -> each returns 8'h10+i, with no aliasing.
